// File: rtl/trackball_counter_if.sv
// CPU-side register port of the trackball counter: read/clear strobes in, read data and movement flag out.
interface trackball_counter_if #(
    parameter int CNT_W = 8
);
    logic             cpu_rd;
    logic             cpu_addr;
    logic             cpu_clr;
    logic [CNT_W-1:0] cpu_dout;
    logic             moved;

    modport master (
        output cpu_rd,
        output cpu_addr,
        output cpu_clr,
        input  cpu_dout,
        input  moved
    );

    modport slave (
        input  cpu_rd,
        input  cpu_addr,
        input  cpu_clr,
        output cpu_dout,
        output moved
    );
endinterface

// File: rtl/trackball_counter.sv
// Trackball position accumulator: synchronises and deglitches the h/v step streams, counts every step
// toggle into wrapping X/Y counters and offers the CPU a coherent X/Y snapshot read.
module trackball_counter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flip,
    input  logic                h_clk,
    input  logic                h_dir,
    input  logic                v_clk,
    input  logic                v_dir,
    trackball_counter_if.slave  bus
);

    localparam int NIN = 4;

    logic [NIN-1:0] raw_in;
    logic [NIN-1:0] sync_q [SYNC_STAGES];
    logic [NIN-1:0] synced;
    logic [NIN-1:0] filt;
    logic [1:0]     filt_prev;

    logic             h_evt, v_evt, h_down, v_down, any_evt;
    logic             rd_x, rd_y;
    logic [CNT_W-1:0] x_cnt, y_cnt, x_step, y_step;
    logic [CNT_W-1:0] snap_y;
    logic [CNT_W-1:0] dout_q;
    logic             moved_q;

    // Bit order: 0 = h_clk, 1 = h_dir, 2 = v_clk, 3 = v_dir
    assign raw_in = {v_dir, v_clk, h_dir, h_clk};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Each filter accepts a new level on the FILTER_LEN-th consecutive disagreeing cycle.
    generate
        if (FILTER_LEN == 0) begin : g_nofilt
            assign filt = synced;
        end else begin : g_filt
            localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
            for (genvar g = 0; g < NIN; g++) begin : g_bit
                logic [FW-1:0] run_cnt;
                logic          filt_bit;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        run_cnt  <= '0;
                        filt_bit <= 1'b0;
                    end else if (synced[g] == filt_bit) begin
                        run_cnt  <= '0;
                    end else if (run_cnt == FW'(FILTER_LEN - 1)) begin
                        run_cnt  <= '0;
                        filt_bit <= synced[g];
                    end else begin
                        run_cnt  <= run_cnt + 1'b1;
                    end
                end

                assign filt[g] = filt_bit;
            end
        end
    endgenerate

    assign h_evt   = filt[0] ^ filt_prev[0];
    assign v_evt   = filt[2] ^ filt_prev[1];
    assign h_down  = filt[1] ^ flip;
    assign v_down  = filt[3] ^ flip;
    assign any_evt = h_evt | v_evt;

    assign x_step = h_down ? (x_cnt - CNT_W'(1)) : (x_cnt + CNT_W'(1));
    assign y_step = v_down ? (y_cnt - CNT_W'(1)) : (y_cnt + CNT_W'(1));

    assign rd_x = bus.cpu_rd & ~bus.cpu_addr;
    assign rd_y = bus.cpu_rd &  bus.cpu_addr;

    // The X snapshot is cpu_dout itself: an X read loads the live X there and it holds until the next read.
    // Reads and snapshots always see pre-event counter values; clear overrides everything in its cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_prev <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            snap_y    <= '0;
            dout_q    <= '0;
            moved_q   <= 1'b0;
        end else begin
            filt_prev <= {filt[2], filt[0]};
            if (bus.cpu_clr) begin
                x_cnt   <= '0;
                y_cnt   <= '0;
                snap_y  <= '0;
                moved_q <= 1'b0;
                if (bus.cpu_rd) begin
                    dout_q <= '0;
                end
            end else begin
                if (h_evt) begin
                    x_cnt <= x_step;
                end
                if (v_evt) begin
                    y_cnt <= y_step;
                end
                if (rd_x) begin
                    snap_y  <= y_cnt;
                    dout_q  <= x_cnt;
                    moved_q <= any_evt;
                end else if (any_evt) begin
                    moved_q <= 1'b1;
                end
                if (rd_y) begin
                    dout_q <= snap_y;
                end
            end
        end
    end

    assign bus.cpu_dout = dout_q;
    assign bus.moved    = moved_q;

endmodule

// File: tb/tb_trackball_counter.sv
// Directed bench for trackball_counter: a table of toggle bursts with hand-computed X/Y results,
// plus hand-written sequences for latency, glitch rejection, snapshot coherence, clear and reset.
module tb_trackball_counter;

    logic clk = 1'b0;
    logic reset_n;
    logic flip, h_clk, h_dir, v_clk, v_dir;

    trackball_counter_if #(.CNT_W(8)) bus ();

    trackball_counter #(
        .CNT_W       (8),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flip    (flip),
        .h_clk   (h_clk),
        .h_dir   (h_dir),
        .v_clk   (v_clk),
        .v_dir   (v_dir),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit       clr;
        bit       flp;
        bit       hd;
        bit       vd;
        int       n_h;
        int       n_v;
        bit       exp_moved;
        logic [7:0] exp_x;
        logic [7:0] exp_y;
    } vec_t;

    vec_t vecs [8];

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    task automatic pulse_clr();
        bus.cpu_clr = 1'b1;
        tick();
        bus.cpu_clr = 1'b0;
    endtask

    task automatic read_check(input bit addr, input logic [7:0] expected, input string name);
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = addr;
        tick();
        bus.cpu_rd   = 1'b0;
        checkOutput(name, bus.cpu_dout, expected);
    endtask

    task automatic toggle_h(input int gap = 20);
        h_clk = ~h_clk;
        tick(gap);
    endtask

    task automatic toggle_v(input int gap = 20);
        v_clk = ~v_clk;
        tick(gap);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.clr) pulse_clr();
        flip  = v.flp;
        h_dir = v.hd;
        v_dir = v.vd;
        tick(20);
        for (int i = 0; i < v.n_h; i++) toggle_h();
        for (int i = 0; i < v.n_v; i++) toggle_v();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // X/Y running values are cumulative across rows; a clr row starts from zero.
        vecs[0] = '{clr:0, flp:0, hd:0, vd:0, n_h:10,  n_v:0, exp_moved:1, exp_x:8'h0A, exp_y:8'h00};
        vecs[1] = '{clr:1, flp:0, hd:1, vd:0, n_h:3,   n_v:0, exp_moved:1, exp_x:8'hFD, exp_y:8'h00};
        vecs[2] = '{clr:0, flp:0, hd:0, vd:0, n_h:259, n_v:0, exp_moved:1, exp_x:8'h00, exp_y:8'h00};
        vecs[3] = '{clr:1, flp:1, hd:0, vd:0, n_h:0,   n_v:5, exp_moved:1, exp_x:8'h00, exp_y:8'hFB};
        vecs[4] = '{clr:0, flp:1, hd:1, vd:0, n_h:2,   n_v:0, exp_moved:1, exp_x:8'h02, exp_y:8'hFB};
        vecs[5] = '{clr:0, flp:0, hd:0, vd:1, n_h:0,   n_v:3, exp_moved:1, exp_x:8'h02, exp_y:8'hF8};
        vecs[6] = '{clr:0, flp:0, hd:0, vd:1, n_h:0,   n_v:0, exp_moved:0, exp_x:8'h02, exp_y:8'hF8};
        vecs[7] = '{clr:0, flp:0, hd:0, vd:0, n_h:4,   n_v:4, exp_moved:1, exp_x:8'h06, exp_y:8'hFC};

        reset_n      = 1'b0;
        flip         = 1'b0;
        h_clk        = 1'b0;
        h_dir        = 1'b0;
        v_clk        = 1'b0;
        v_dir        = 1'b0;
        bus.cpu_rd   = 1'b0;
        bus.cpu_addr = 1'b0;
        bus.cpu_clr  = 1'b0;

        tick(3);
        checkOutput("reset_dout", bus.cpu_dout, 8'h00);
        checkOutput("reset_moved", {7'd0, bus.moved}, 8'h00);
        #3 reset_n = 1'b1;
        tick(2);
        read_check(1'b0, 8'h00, "reset_x");
        read_check(1'b1, 8'h00, "reset_y");

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("vec%0d_moved", k), {7'd0, bus.moved}, {7'd0, vecs[k].exp_moved});
            read_check(1'b0, vecs[k].exp_x, $sformatf("vec%0d_x", k));
            checkOutput($sformatf("vec%0d_moved_clr", k), {7'd0, bus.moved}, 8'h00);
            read_check(1'b1, vecs[k].exp_y, $sformatf("vec%0d_y", k));
        end

        // Exact toggle-to-count latency, observed through the moved flag.
        pulse_clr();
        flip  = 1'b1;
        v_dir = 1'b0;
        tick(20);
        for (int t = 0; t < 2; t++) begin
            v_clk = ~v_clk;
            for (int c = 1; c <= 7; c++) begin
                tick();
                checkOutput($sformatf("lat%0d_cyc%0d", t, c), {7'd0, bus.moved}, (c == 7) ? 8'h01 : 8'h00);
            end
            tick(10);
            read_check(1'b0, 8'h00, $sformatf("lat%0d_x", t));
        end
        read_check(1'b1, 8'hFE, "lat_y");

        // Glitch rejection: 3-cycle pulse ignored, 5-cycle pulse counts both edges.
        pulse_clr();
        flip  = 1'b0;
        h_dir = 1'b0;
        tick(20);
        h_clk = ~h_clk;
        tick(3);
        h_clk = ~h_clk;
        tick(20);
        checkOutput("glitch3_moved", {7'd0, bus.moved}, 8'h00);
        read_check(1'b0, 8'h00, "glitch3_x");
        h_clk = ~h_clk;
        tick(5);
        h_clk = ~h_clk;
        tick(20);
        checkOutput("pulse5_moved", {7'd0, bus.moved}, 8'h01);
        read_check(1'b0, 8'h02, "pulse5_x");

        // Snapshot coherence: Y read returns the value frozen by the preceding X read.
        pulse_clr();
        v_dir = 1'b0;
        tick(20);
        for (int i = 0; i < 4; i++) toggle_h();
        for (int i = 0; i < 9; i++) toggle_v();
        read_check(1'b0, 8'h04, "snap_x");
        toggle_v();
        toggle_v();
        read_check(1'b1, 8'h09, "snap_y_old");
        read_check(1'b0, 8'h04, "snap_x_again");
        read_check(1'b1, 8'h0B, "snap_y_new");

        // X read in the same cycle as a count event: pre-event value, moved stays set.
        h_clk = ~h_clk;
        tick(6);
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 1'b0;
        tick();
        bus.cpu_rd   = 1'b0;
        checkOutput("evtrd_dout", bus.cpu_dout, 8'h04);
        checkOutput("evtrd_moved", {7'd0, bus.moved}, 8'h01);
        read_check(1'b1, 8'h0B, "evtrd_y");
        read_check(1'b0, 8'h05, "evtrd_x_after");
        checkOutput("evtrd_moved_clr", {7'd0, bus.moved}, 8'h00);

        // Simultaneous events on both axes both count.
        h_clk = ~h_clk;
        v_clk = ~v_clk;
        tick(20);
        read_check(1'b0, 8'h06, "both_x");
        read_check(1'b1, 8'h0C, "both_y");

        // Clear coincident with a count event and a read: everything zero, event dropped.
        h_clk = ~h_clk;
        tick(6);
        bus.cpu_clr  = 1'b1;
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 1'b0;
        tick();
        bus.cpu_clr  = 1'b0;
        bus.cpu_rd   = 1'b0;
        checkOutput("clr_dout", bus.cpu_dout, 8'h00);
        checkOutput("clr_moved", {7'd0, bus.moved}, 8'h00);
        tick(20);
        checkOutput("clr_moved_late", {7'd0, bus.moved}, 8'h00);
        read_check(1'b0, 8'h00, "clr_x");
        read_check(1'b1, 8'h00, "clr_y");

        // Reset asserted mid-burst clears outputs at once; a high h_clk at release counts once.
        toggle_h();
        read_check(1'b0, 8'h01, "prerst_x");
        toggle_h();
        checkOutput("prerst_moved", {7'd0, bus.moved}, 8'h01);
        toggle_h(3);
        checkOutput("prerst_dout", bus.cpu_dout, 8'h01);
        #3;
        reset_n = 1'b0;
        h_clk   = 1'b1;
        h_dir   = 1'b0;
        #1;
        checkOutput("rst_dout", bus.cpu_dout, 8'h00);
        checkOutput("rst_moved", {7'd0, bus.moved}, 8'h00);
        tick(3);
        #3 reset_n = 1'b1;
        tick(20);
        checkOutput("postrst_moved", {7'd0, bus.moved}, 8'h01);
        read_check(1'b0, 8'h01, "postrst_x");
        read_check(1'b1, 8'h00, "postrst_y");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
